// File: rtl/alu_issue_if.sv
// Handshake bundle between decode, the ALU issue slot and execute.
// The stage takes the slave view; whoever drives decode/execute takes the master view.
interface alu_issue_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_value;
    logic [31:0] in_rt_value;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_control;
    logic [31:0] out_src1;
    logic [31:0] out_src2;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic        out_illegal;

    modport slave (
        input  flush, in_valid, in_instr, in_rs_value, in_rt_value, out_ready,
        output in_ready, out_valid, out_control, out_src1, out_src2,
               out_dest, out_wen, out_illegal
    );

    modport master (
        output flush, in_valid, in_instr, in_rs_value, in_rt_value, out_ready,
        input  in_ready, out_valid, out_control, out_src1, out_src2,
               out_dest, out_wen, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Decodes a MIPS-style instruction into ALU control/operands/destination and
// holds the result in one registered slot with valid/ready backpressure.
module alu_issue_stage #(
    parameter bit CUSTOM_OPS = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    alu_issue_if.slave   bus
);

    typedef enum logic [3:0] {
        ALU_ILLEGAL = 4'b0000,
        ALU_ADD     = 4'b0001,
        ALU_SUB     = 4'b0010,
        ALU_SLT     = 4'b0011,
        ALU_SLTU    = 4'b0100,
        ALU_AND     = 4'b0101,
        ALU_NOR     = 4'b0110,
        ALU_OR      = 4'b0111,
        ALU_XOR     = 4'b1000,
        ALU_SLL     = 4'b1001,
        ALU_SRL     = 4'b1010,
        ALU_SRA     = 4'b1011,
        ALU_LUI     = 4'b1100,
        ALU_XNOR    = 4'b1101,
        ALU_INC     = 4'b1110,
        ALU_LH      = 4'b1111
    } alu_op_t;

    // Instruction fields
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign op       = bus.in_instr[31:26];
    assign rt       = bus.in_instr[20:16];
    assign rd       = bus.in_instr[15:11];
    assign sh       = bus.in_instr[10:6];
    assign fn       = bus.in_instr[5:0];
    assign imm      = bus.in_instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'd0, imm};

    // Raw decode, before the illegal case is squashed to all-zero
    alu_op_t     raw_control;
    logic [31:0] raw_src1;
    logic [31:0] raw_src2;
    logic [4:0]  raw_dest;

    always_comb begin
        raw_control = ALU_ILLEGAL;
        raw_src1    = '0;
        raw_src2    = '0;
        raw_dest    = '0;
        case (op)
            6'b000000: begin
                raw_src1 = bus.in_rs_value;
                raw_src2 = bus.in_rt_value;
                raw_dest = rd;
                case (fn)
                    6'b100000, 6'b100001: raw_control = ALU_ADD;
                    6'b100010, 6'b100011: raw_control = ALU_SUB;
                    6'b100100:            raw_control = ALU_AND;
                    6'b100101:            raw_control = ALU_OR;
                    6'b100110:            raw_control = ALU_XOR;
                    6'b100111:            raw_control = ALU_NOR;
                    6'b101010:            raw_control = ALU_SLT;
                    6'b101011:            raw_control = ALU_SLTU;
                    6'b101000: begin
                        if (CUSTOM_OPS) begin
                            raw_control = ALU_XNOR;
                        end
                    end
                    6'b000000: begin
                        raw_control = ALU_SLL;
                        raw_src1    = {27'd0, sh};
                    end
                    6'b000010: begin
                        raw_control = ALU_SRL;
                        raw_src1    = {27'd0, sh};
                    end
                    6'b000011: begin
                        raw_control = ALU_SRA;
                        raw_src1    = {27'd0, sh};
                    end
                    6'b000100: raw_control = ALU_SLL;
                    6'b000110: raw_control = ALU_SRL;
                    6'b000111: raw_control = ALU_SRA;
                    default:   raw_control = ALU_ILLEGAL;
                endcase
            end
            6'b001000, 6'b001001: begin
                raw_control = ALU_ADD;
                raw_src1    = bus.in_rs_value;
                raw_src2    = imm_sext;
                raw_dest    = rt;
            end
            6'b001010, 6'b001011: begin
                raw_control = (op[0]) ? ALU_SLTU : ALU_SLT;
                raw_src1    = bus.in_rs_value;
                raw_src2    = imm_sext;
                raw_dest    = rt;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                case (op[1:0])
                    2'b00:   raw_control = ALU_AND;
                    2'b01:   raw_control = ALU_OR;
                    default: raw_control = ALU_XOR;
                endcase
                raw_src1 = bus.in_rs_value;
                raw_src2 = imm_zext;
                raw_dest = rt;
            end
            6'b001111: begin
                raw_control = ALU_LUI;
                raw_src1    = bus.in_rs_value;
                raw_src2    = imm_zext;
                raw_dest    = rt;
            end
            6'b011100: begin
                if (CUSTOM_OPS) begin
                    raw_control = ALU_INC;
                    raw_src1    = bus.in_rs_value;
                    raw_dest    = rt;
                end
            end
            6'b011101: begin
                if (CUSTOM_OPS) begin
                    raw_control = ALU_LH;
                    raw_src2    = imm_zext;
                    raw_dest    = rt;
                end
            end
            default: raw_control = ALU_ILLEGAL;
        endcase
    end

    // Illegal words still issue, but with every payload field cleared
    logic        dec_legal;
    logic [3:0]  dec_control;
    logic [31:0] dec_src1;
    logic [31:0] dec_src2;
    logic [4:0]  dec_dest;
    logic        dec_wen;

    assign dec_legal   = (raw_control != ALU_ILLEGAL);
    assign dec_control = raw_control;
    assign dec_src1    = dec_legal ? raw_src1 : 32'd0;
    assign dec_src2    = dec_legal ? raw_src2 : 32'd0;
    assign dec_dest    = dec_legal ? raw_dest : 5'd0;
    assign dec_wen     = dec_legal && (raw_dest != 5'd0);

    // Pipeline slot
    logic        valid_reg;
    logic [3:0]  control_reg;
    logic [31:0] src1_reg;
    logic [31:0] src2_reg;
    logic [4:0]  dest_reg;
    logic        wen_reg;
    logic        illegal_reg;
    logic        ready;
    logic        accept;

    assign ready  = !valid_reg || bus.out_ready;
    assign accept = bus.in_valid && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg   <= 1'b0;
            control_reg <= '0;
            src1_reg    <= '0;
            src2_reg    <= '0;
            dest_reg    <= '0;
            wen_reg     <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (bus.flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg   <= 1'b1;
            control_reg <= dec_control;
            src1_reg    <= dec_src1;
            src2_reg    <= dec_src2;
            dest_reg    <= dec_dest;
            wen_reg     <= dec_wen;
            illegal_reg <= !dec_legal;
        end else if (bus.out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = valid_reg;
    assign bus.out_control = control_reg;
    assign bus.out_src1    = src1_reg;
    assign bus.out_src2    = src2_reg;
    assign bus.out_dest    = dest_reg;
    assign bus.out_wen     = wen_reg;
    assign bus.out_illegal = illegal_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: two instances (custom ops on/off) share stimulus and
// are checked every cycle against a queue-based reference, plus literal spot checks.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if bus1 ();
    alu_issue_if bus0 ();

    alu_issue_stage #(.CUSTOM_OPS(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    alu_issue_stage #(.CUSTOM_OPS(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

    assign bus0.flush       = bus1.flush;
    assign bus0.in_valid    = bus1.in_valid;
    assign bus0.in_instr    = bus1.in_instr;
    assign bus0.in_rs_value = bus1.in_rs_value;
    assign bus0.in_rt_value = bus1.in_rt_value;
    assign bus0.out_ready   = bus1.out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  d;
        logic        wen;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
    } txn_t;

    // Reference decode straight from the instruction-set table
    function automatic exp_t ref_dec(input txn_t t, input bit custom);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        logic [31:0] sx;
        logic [31:0] zx;
        op = t.instr[31:26];
        fn = t.instr[5:0];
        zx = {16'd0, t.instr[15:0]};
        sx = {{16{t.instr[15]}}, t.instr[15:0]};
        e = '0;
        if (op == 6'd0) begin
            e.s1 = t.rs;
            e.s2 = t.rt;
            e.d  = t.instr[15:11];
            case (fn)
                6'h20, 6'h21: e.ctl = 4'd1;
                6'h22, 6'h23: e.ctl = 4'd2;
                6'h24: e.ctl = 4'd5;
                6'h25: e.ctl = 4'd7;
                6'h26: e.ctl = 4'd8;
                6'h27: e.ctl = 4'd6;
                6'h2A: e.ctl = 4'd3;
                6'h2B: e.ctl = 4'd4;
                6'h28: e.ctl = custom ? 4'd13 : 4'd0;
                6'h00: begin e.ctl = 4'd9;  e.s1 = 32'(t.instr[10:6]); end
                6'h02: begin e.ctl = 4'd10; e.s1 = 32'(t.instr[10:6]); end
                6'h03: begin e.ctl = 4'd11; e.s1 = 32'(t.instr[10:6]); end
                6'h04: e.ctl = 4'd9;
                6'h06: e.ctl = 4'd10;
                6'h07: e.ctl = 4'd11;
                default: e.ctl = 4'd0;
            endcase
        end else begin
            e.s1 = t.rs;
            e.d  = t.instr[20:16];
            case (op)
                6'h08, 6'h09: begin e.ctl = 4'd1;  e.s2 = sx; end
                6'h0A:        begin e.ctl = 4'd3;  e.s2 = sx; end
                6'h0B:        begin e.ctl = 4'd4;  e.s2 = sx; end
                6'h0C:        begin e.ctl = 4'd5;  e.s2 = zx; end
                6'h0D:        begin e.ctl = 4'd7;  e.s2 = zx; end
                6'h0E:        begin e.ctl = 4'd8;  e.s2 = zx; end
                6'h0F:        begin e.ctl = 4'd12; e.s2 = zx; end
                6'h1C:        begin e.ctl = custom ? 4'd14 : 4'd0; e.s2 = 32'd0; end
                6'h1D:        begin e.ctl = custom ? 4'd15 : 4'd0; e.s1 = 32'd0; e.s2 = zx; end
                default:      e.ctl = 4'd0;
            endcase
        end
        if (e.ctl == 4'd0) begin
            e = '0;
            e.ill = 1'b1;
        end else begin
            e.wen = (e.d != 5'd0);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // Reference slot: a queue holding at most one accepted transaction
    txn_t mdl_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_q.delete();
        end else if (bus1.flush) begin
            mdl_q.delete();
        end else begin
            bit acc;
            acc = bus1.in_valid && (mdl_q.size() == 0 || bus1.out_ready);
            if (mdl_q.size() != 0 && bus1.out_ready) void'(mdl_q.pop_front());
            if (acc) mdl_q.push_back('{instr: bus1.in_instr, rs: bus1.in_rs_value, rt: bus1.in_rt_value});
        end
    end

    // Per-cycle compare of both instances against the reference
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            exp_t e1;
            exp_t e0;
            bit   ev;
            ev = (mdl_q.size() != 0);
            chk("in_ready", {31'd0, bus1.in_ready}, {31'd0, !ev || bus1.out_ready});
            chk("out_valid", {31'd0, bus1.out_valid}, {31'd0, ev});
            chk("out_valid_c0", {31'd0, bus0.out_valid}, {31'd0, ev});
            if (ev) begin
                e1 = ref_dec(mdl_q[0], 1'b1);
                e0 = ref_dec(mdl_q[0], 1'b0);
                chk("control", {28'd0, bus1.out_control}, {28'd0, e1.ctl});
                chk("src1", bus1.out_src1, e1.s1);
                chk("src2", bus1.out_src2, e1.s2);
                chk("dest", {27'd0, bus1.out_dest}, {27'd0, e1.d});
                chk("wen", {31'd0, bus1.out_wen}, {31'd0, e1.wen});
                chk("illegal", {31'd0, bus1.out_illegal}, {31'd0, e1.ill});
                chk("control_c0", {28'd0, bus0.out_control}, {28'd0, e0.ctl});
                chk("src1_c0", bus0.out_src1, e0.s1);
                chk("src2_c0", bus0.out_src2, e0.s2);
                chk("dest_c0", {27'd0, bus0.out_dest}, {27'd0, e0.d});
                chk("wen_c0", {31'd0, bus0.out_wen}, {31'd0, e0.wen});
                chk("illegal_c0", {31'd0, bus0.out_illegal}, {31'd0, e0.ill});
            end
        end
    end

    task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        bus1.in_valid    = 1'b1;
        bus1.in_instr    = instr;
        bus1.in_rs_value = rs;
        bus1.in_rt_value = rt;
        bus1.out_ready   = 1'b1;
        bus1.flush       = 1'b0;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        $display("issue instr=%h rs=%h rt=%h -> valid=%b ctl=%h src1=%h src2=%h dest=%0d wen=%b ill=%b",
                 instr, rs, rt, bus1.out_valid, bus1.out_control, bus1.out_src1,
                 bus1.out_src2, bus1.out_dest, bus1.out_wen, bus1.out_illegal);
    endtask

    logic [5:0] fn_pool [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h28, 6'h00, 6'h02, 6'h03, 6'h04, 6'h07};
    logic [5:0] op_pool [12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h1C, 6'h1D, 6'h3F, 6'h23};

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4) begin
            w[31:26] = 6'd0;
            w[5:0]   = fn_pool[$urandom_range(0, 15)];
        end else if (k < 9) begin
            w[31:26] = op_pool[$urandom_range(0, 11)];
        end
        return w;
    endfunction

    initial begin
        bus1.flush       = 1'b0;
        bus1.in_valid    = 1'b0;
        bus1.in_instr    = '0;
        bus1.in_rs_value = '0;
        bus1.in_rt_value = '0;
        bus1.out_ready   = 1'b1;
        #1;
        chk("rst_valid", {31'd0, bus1.out_valid}, 32'd0);
        chk("rst_ready", {31'd0, bus1.in_ready}, 32'd1);
        chk("rst_src1", bus1.out_src1, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        issue(32'h00221821, 32'd5, 32'd7);
        chk("lit_add_valid", {31'd0, bus1.out_valid}, 32'd1);
        chk("lit_add_ctl", {28'd0, bus1.out_control}, 32'h1);
        chk("lit_add_s1", bus1.out_src1, 32'd5);
        chk("lit_add_s2", bus1.out_src2, 32'd7);
        chk("lit_add_dest", {27'd0, bus1.out_dest}, 32'd3);
        chk("lit_add_wen", {31'd0, bus1.out_wen}, 32'd1);

        issue(32'h000220C0, 32'd99, 32'd1);
        chk("lit_sll_ctl", {28'd0, bus1.out_control}, 32'h9);
        chk("lit_sll_s1", bus1.out_src1, 32'd3);
        chk("lit_sll_dest", {27'd0, bus1.out_dest}, 32'd4);

        issue(32'h2425FFFF, 32'd1, 32'd2);
        chk("lit_addiu_s2", bus1.out_src2, 32'hFFFFFFFF);
        chk("lit_addiu_dest", {27'd0, bus1.out_dest}, 32'd5);

        issue(32'h3025FFFF, 32'd1, 32'd2);
        chk("lit_andi_ctl", {28'd0, bus1.out_control}, 32'h5);
        chk("lit_andi_s2", bus1.out_src2, 32'h0000FFFF);

        issue(32'hFC000000, 32'd1, 32'd2);
        chk("lit_ill", {31'd0, bus1.out_illegal}, 32'd1);
        chk("lit_ill_valid", {31'd0, bus1.out_valid}, 32'd1);
        chk("lit_ill_wen", {31'd0, bus1.out_wen}, 32'd0);

        issue(32'h00220021, 32'd1, 32'd2);
        chk("lit_r0_wen", {31'd0, bus1.out_wen}, 32'd0);
        chk("lit_r0_ill", {31'd0, bus1.out_illegal}, 32'd0);

        issue(32'h70220000, 32'd9, 32'd4);
        chk("lit_inc_ctl", {28'd0, bus1.out_control}, 32'hE);
        chk("lit_inc_dest", {27'd0, bus1.out_dest}, 32'd2);
        chk("lit_inc_c0_ill", {31'd0, bus0.out_illegal}, 32'd1);

        // Backpressure: slot holds while execute stalls
        issue(32'h00221821, 32'd5, 32'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus1.out_ready = 1'b0;
            bus1.in_valid  = 1'b1;
            bus1.in_instr  = (i == 2) ? 32'h000220C0 : 32'h3025FFFF;
            bus1.in_rt_value = 32'd1;
            @(posedge clk);
            #1;
            chk("lit_bp_ready", {31'd0, bus1.in_ready}, 32'd0);
            chk("lit_bp_s1", bus1.out_src1, 32'd5);
        end
        @(negedge clk);
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        chk("lit_bp_next", {28'd0, bus1.out_control}, 32'h9);

        // Flush with a full slot and a same-cycle input
        @(negedge clk);
        bus1.out_ready = 1'b0;
        bus1.in_valid  = 1'b1;
        bus1.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus1.flush    = 1'b0;
        bus1.in_valid = 1'b0;
        chk("lit_flush", {31'd0, bus1.out_valid}, 32'd0);

        // Asynchronous reset mid-cycle with a full slot
        issue(32'h00221821, 32'd5, 32'd7);
        bus1.out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("lit_arst_valid", {31'd0, bus1.out_valid}, 32'd0);
        chk("lit_arst_s1", bus1.out_src1, 32'd0);
        chk("lit_arst_dest", {27'd0, bus1.out_dest}, 32'd0);
        chk("lit_arst_ready", {31'd0, bus1.in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            bus1.in_valid    = ($urandom_range(0, 3) != 0);
            bus1.out_ready   = ($urandom_range(0, 2) != 0);
            bus1.flush       = ($urandom_range(0, 31) == 0);
            bus1.in_instr    = rand_instr();
            bus1.in_rs_value = $urandom;
            bus1.in_rt_value = $urandom;
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.flush    = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue register sitting directly upstream of the execute-stage ALU.
- Accepts one raw 32-bit MIPS-style instruction plus its register-file operand values from decode over a valid/ready handshake.
- Produces the ALU's 4-bit operation code, src1/src2 operands, and writeback destination.
- Holds them in a single registered pipeline slot with valid/ready backpressure toward execute.

Parameters:
CUSTOM_OPS, 1, when 1 the team-custom xnor/inc/lh encodings decode legally; when 0 they decode as illegal.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of the held slot and of any same-cycle input
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
in_instr  input  32  raw instruction word
in_rs_value  input  32  value of register rs
in_rt_value  input  32  value of register rt
out_valid  output  1  slot holds a valid issued op
out_ready  input  1  execute consumes slot this cycle
out_control  output  4  ALU op code
out_src1  output  32  ALU src1 (shift amount in bits [4:0] for shifts)
out_src2  output  32  ALU src2
out_dest  output  5  writeback register index
out_wen  output  1  writeback enable
out_illegal  output  1  instruction not recognised

Behaviour:
- ALU codes: add 0001, sub 0010, slt 0011, sltu 0100, and 0101, nor 0110, or 0111, xor 1000, sll 1001, srl 1010, sra 1011, lui 1100, xnor 1101, inc 1110, lh 1111, illegal 0000.
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sh=[10:6], fn=[5:0], imm=[15:0].
- SPECIAL (op=000000), dest=rd, src1=rs_value, src2=rt_value unless noted:
  - fn 100000/100001 add.
  - fn 100010/100011 sub.
  - fn 100100 and; 100101 or; 100110 xor; 100111 nor.
  - fn 101010 slt; 101011 sltu.
  - fn 101000 xnor (custom).
  - fn 000000/000010/000011 sll/srl/sra with src1={27'd0,sh}.
  - fn 000100/000110/000111 sllv/srlv/srav with src1=rs_value.
  - All other fn illegal.
- I-type, dest=rt, src1=rs_value:
  - op 001000/001001 add, src2=sign-extended imm.
  - op 001010 slt and op 001011 sltu, src2=sign-extended imm.
  - op 001100 and, 001101 or, 001110 xor, src2=zero-extended imm.
  - op 001111 lui, src2={16'd0,imm}.
- Custom ops:
  - op 011100 inc, src1=rs_value, src2=0, dest=rt.
  - op 011101 lh, src2={16'd0,imm}, src1=0, dest=rt.
  - Both illegal when CUSTOM_OPS=0.
- Illegal decode: control=0000, src1=src2=0, dest=0, wen=0, illegal=1. The slot still issues (out_valid=1) so execute can trap.
- out_wen = legal && dest!=0.
- in_ready = !out_valid || out_ready (combinational).
- Accept when in_valid && in_ready. Decoded values appear on outputs the next edge, latency 1 cycle. Full throughput when out_ready held high.
- Slot empties (out_valid->0) on an edge with out_valid && out_ready && no accept.
- While out_valid && !out_ready, all out_* held bit-stable.
- flush=1 at an edge: out_valid->0 and any same-cycle accept is discarded. Flush has priority over accept and hold. in_ready is unaffected by flush.
- Reset (any time, including mid-transfer): out_valid=0, out_control=0, out_src1=0, out_src2=0, out_dest=0, out_wen=0, out_illegal=0. in_ready therefore 1 during reset.
- Data outputs are don't-care when out_valid=0 but are reset to 0.

Test Plan:
- Add: in_instr=0x00221821 (addu $3,$1,$2), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, control=0001, src1=5, src2=7, dest=3, wen=1, illegal=0.
- Shift and immediate: 0x00022C00... use 0x000220C0 (sll $4,$2,3) with rt=1 -> control=1001, src1=3, src2=1, dest=4. Then 0x2425FFFF -> control=0001, src2=0xFFFFFFFF, dest=5. Then 0x3025FFFF -> control=0101, src2=0x0000FFFF.
- Backpressure: issue 0x00221821, hold out_ready=0 three cycles with in_valid=1 and new instrs -> in_ready=0, outputs unchanged. On out_ready=1, the next instr is accepted with no loss or duplication, checked by scoreboard over 1000 random valid/ready patterns.
- Illegal and zero dest:
  - 0xFC000000 -> illegal=1, control=0000, wen=0, out_valid=1.
  - 0x00220021 (dest $0) -> wen=0, illegal=0.
  - With CUSTOM_OPS=0, 0x70220000 -> illegal=1; with CUSTOM_OPS=1 -> control=1110, src2=0, dest=2.
- Flush and reset: flush while slot full and in_valid=1 -> out_valid=0 next cycle, input dropped. Assert reset asynchronously mid-cycle with slot full -> out_valid and all outputs 0 immediately, before the next clk edge.
